// File: rtl/codec_cfg_pkg.sv
// Shared configuration for codec_init_sequencer: command count, FSM encoding and the WM8731 init table.
// CODEC_SEQ_VOLUME_EN adds the VOL_LOAD state and the headphone-volume command fields.
package codec_cfg_pkg;

  localparam int NUM_CMDS = 11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_DONE,
    RELEASE,
    GAP,
    DONE
`ifdef CODEC_SEQ_VOLUME_EN
    , VOL_LOAD
`endif
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] val;
  } cmd_t;

`ifdef CODEC_SEQ_VOLUME_EN
  // Left headphone out register; control bits placed above the 7-bit volume.
  localparam logic [6:0] VOL_REG  = 7'h02;
  localparam logic [1:0] VOL_CTRL = 2'b01;
`endif

  // WM8731 power-up order: reset, power, line-in, headphone, path, format, rate, activate.
  function automatic cmd_t init_cmd(input logic [3:0] idx);
    cmd_t c;
    case (idx)
      4'd0:    c = '{addr: 7'd15, val: 9'h000};
      4'd1:    c = '{addr: 7'd6,  val: 9'h000};
      4'd2:    c = '{addr: 7'd0,  val: 9'h017};
      4'd3:    c = '{addr: 7'd1,  val: 9'h017};
      4'd4:    c = '{addr: 7'd2,  val: 9'h079};
      4'd5:    c = '{addr: 7'd3,  val: 9'h079};
      4'd6:    c = '{addr: 7'd4,  val: 9'h012};
      4'd7:    c = '{addr: 7'd5,  val: 9'h000};
      4'd8:    c = '{addr: 7'd7,  val: 9'h001};
      4'd9:    c = '{addr: 7'd8,  val: 9'h000};
      4'd10:   c = '{addr: 7'd9,  val: 9'h001};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the I2C controller's finished flag into the clock domain.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: flops take non-blocking assignments so meta and q both sample pre-edge values.
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the WM8731 init table, handing one 24-bit word at a time to an I2C controller.
// Optional macro CODEC_SEQ_VOLUME_EN adds a headphone-volume command issued from DONE.
module codec_init_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int         GAP_CYCLES     = 32,
  parameter int         TIMEOUT_CYCLES = 65536,
  parameter logic [7:0] DEV_ADDR       = 8'h34
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        i2c_finished,
`ifdef CODEC_SEQ_VOLUME_EN
  input  logic        vol_req,
  input  logic [6:0]  vol_value,
  output logic        vol_ack,
`endif
  output logic [23:0] i2c_data,
  output logic        i2c_reset,
  output logic        busy,
  output logic        init_done,
  output logic        err,
  output logic [3:0]  cmd_index
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int             GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]     IDX_LAST = 4'(NUM_CMDS - 1);

  state_t        state, state_next;
  logic [3:0]    idx_next;
  logic [23:0]   data_next;
  logic [TW-1:0] tmo_cnt, tmo_next;
  logic [GW-1:0] gap_cnt, gap_next;
  logic          err_next, done_next;
  logic          fin_s;
`ifdef CODEC_SEQ_VOLUME_EN
  logic          vol_active, vol_active_next, ack_next;
`endif

  sync_2ff u_fin_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (i2c_finished),
    .q       (fin_s)
  );

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    state_next = state;
    idx_next   = cmd_index;
    data_next  = i2c_data;
    tmo_next   = tmo_cnt;
    gap_next   = gap_cnt;
    err_next   = err;
    done_next  = init_done;
`ifdef CODEC_SEQ_VOLUME_EN
    vol_active_next = vol_active;
    ack_next        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          idx_next   = '0;
        end
      end
      LOAD: begin
        data_next  = {DEV_ADDR, init_cmd(cmd_index)};
        state_next = SEND;
      end
`ifdef CODEC_SEQ_VOLUME_EN
      VOL_LOAD: begin
        data_next  = {DEV_ADDR, VOL_REG, VOL_CTRL, vol_value};
        state_next = SEND;
      end
`endif
      SEND: begin
        tmo_next   = '0;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A finished flag arriving on the last allowed cycle still counts as success.
        if (fin_s) begin
          state_next = RELEASE;
        end else if (tmo_cnt == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = RELEASE;
        end else begin
          tmo_next = tmo_cnt + 1'b1;
        end
      end
      RELEASE: begin
        gap_next = '0;
        if (!fin_s) state_next = GAP;
      end
      GAP: begin
        if (gap_cnt != GAP_LAST) begin
          gap_next = gap_cnt + 1'b1;
`ifdef CODEC_SEQ_VOLUME_EN
        end else if (vol_active) begin
          state_next      = DONE;
          vol_active_next = 1'b0;
          ack_next        = 1'b1;
`endif
        end else if (cmd_index == IDX_LAST) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          idx_next   = cmd_index + 1'b1;
          state_next = LOAD;
        end
      end
      DONE: begin
        if (start) begin
          state_next = LOAD;
          idx_next   = '0;
          done_next  = 1'b0;
`ifdef CODEC_SEQ_VOLUME_EN
        end else if (vol_req) begin
          state_next      = VOL_LOAD;
          vol_active_next = 1'b1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_index <= '0;
      i2c_data  <= '0;
      i2c_reset <= 1'b1;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      err       <= 1'b0;
      init_done <= 1'b0;
`ifdef CODEC_SEQ_VOLUME_EN
      vol_active <= 1'b0;
      vol_ack    <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cmd_index <= idx_next;
      i2c_data  <= data_next;
      tmo_cnt   <= tmo_next;
      gap_cnt   <= gap_next;
      err       <= err_next;
      init_done <= done_next;
      // Registered so the cross-domain enable never glitches on state decode.
      i2c_reset <= !(state_next == SEND || state_next == WAIT_DONE);
`ifdef CODEC_SEQ_VOLUME_EN
      vol_active <= vol_active_next;
      vol_ack    <= ack_next;
`endif
    end
  end

  assign busy = !(state == IDLE || state == DONE);

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Self-checking bench for codec_init_sequencer with a behavioural I2C controller and a command scoreboard.
// Define CODEC_SEQ_VOLUME_EN to also exercise the volume command.
module tb_codec_init_sequencer;
  import codec_cfg_pkg::*;

  localparam int GAP_N      = 4;
  localparam int TMO_N      = 1000;
  localparam int FIN_DELAY  = 200;
  localparam int DROP_DELAY = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        i2c_finished = 1'b0;
  logic [23:0] i2c_data;
  logic        i2c_reset, busy, init_done, err;
  logic [3:0]  cmd_index;
`ifdef CODEC_SEQ_VOLUME_EN
  logic        vol_req = 1'b0;
  logic [6:0]  vol_value = 7'h00;
  logic        vol_ack;
`endif

  codec_init_sequencer #(
    .GAP_CYCLES     (GAP_N),
    .TIMEOUT_CYCLES (TMO_N),
    .DEV_ADDR       (8'h34)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .i2c_finished (i2c_finished),
`ifdef CODEC_SEQ_VOLUME_EN
    .vol_req      (vol_req),
    .vol_value    (vol_value),
    .vol_ack      (vol_ack),
`endif
    .i2c_data     (i2c_data),
    .i2c_reset    (i2c_reset),
    .busy         (busy),
    .init_done    (init_done),
    .err          (err),
    .cmd_index    (cmd_index)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  idx;
    logic [23:0] word;
  } vec_t;

  vec_t table_v [NUM_CMDS];
  vec_t sb_q [$];

  int checks = 0;
  int errors = 0;
  int n_cmds = 0;
  int seq_cmd = 0;
  int hang_cmd = -1;
  int low_len = 0;
  int tmo_len = -1;
  logic tmo_err_rise = 1'b0;
  logic last_err_low = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected word on every falling i2c_reset, checks hold while low.
  initial begin
    logic        prev_rst;
    logic [23:0] held;
    vec_t        e;
    prev_rst = 1'b1;
    held     = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_rst = 1'b1;
        low_len  = 0;
      end else begin
        if (prev_rst && !i2c_reset) begin
          n_cmds++;
          seq_cmd++;
          held    = i2c_data;
          low_len = 1;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: word 0x%0h issued, none expected", i2c_data);
          end else begin
            e = sb_q.pop_front();
            check("cmd_word", {8'h00, i2c_data}, {8'h00, e.word});
            check("cmd_index", {28'h0, cmd_index}, {28'h0, e.idx});
          end
          if (seq_cmd - 1 == hang_cmd) last_err_low = err;
        end else if (!i2c_reset) begin
          low_len++;
          check("data_stable", {8'h00, i2c_data}, {8'h00, held});
          if (seq_cmd - 1 == hang_cmd) last_err_low = err;
        end else if (!prev_rst) begin
          if (seq_cmd - 1 == hang_cmd) begin
            tmo_len      = low_len;
            tmo_err_rise = err;
          end
        end
        prev_rst = i2c_reset;
      end
    end
  end

  // I2C controller model: finished rises FIN_DELAY clocks after i2c_reset falls, drops DROP_DELAY after it rises.
  initial begin
    int lo;
    int hi;
    lo = 0;
    hi = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        i2c_finished = 1'b0;
        lo = 0;
        hi = 0;
      end else if (!i2c_reset) begin
        hi = 0;
        lo++;
        if (lo == FIN_DELAY && seq_cmd - 1 != hang_cmd) i2c_finished = 1'b1;
      end else begin
        lo = 0;
        if (i2c_finished) begin
          hi++;
          if (hi == DROP_DELAY) begin
            i2c_finished = 1'b0;
            hi = 0;
          end
        end
      end
    end
  end

  task automatic push_all();
    for (int i = 0; i < NUM_CMDS; i++) sb_q.push_back(table_v[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(busy === 1'b0 && init_done === 1'b1) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: not done after %0d cycles", name, n);
    end
  endtask

  task automatic wait_cmds(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (seq_cmd < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: command %0d not seen after %0d cycles", name, target, n);
    end
  endtask

  initial begin
    int n;
    int n0;
`ifdef CODEC_SEQ_VOLUME_EN
    int acks;
    vec_t vv;
    logic [23:0] vol_word;
`endif
    table_v = '{
      '{4'd0,  24'h341E00}, '{4'd1,  24'h340C00}, '{4'd2,  24'h340017},
      '{4'd3,  24'h340217}, '{4'd4,  24'h340479}, '{4'd5,  24'h340679},
      '{4'd6,  24'h340812}, '{4'd7,  24'h340A00}, '{4'd8,  24'h340E01},
      '{4'd9,  24'h341000}, '{4'd10, 24'h341201}
    };

    // Reset state and no activity without start.
    repeat (3) @(negedge clock);
    check("rst_i2c_reset", {31'h0, i2c_reset}, 32'h1);
    check("rst_i2c_data", {8'h00, i2c_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_init_done", {31'h0, init_done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_cmd_index", {28'h0, cmd_index}, 32'h0);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("idle_no_cmd", n_cmds, 0);
    check("idle_busy", {31'h0, busy}, 32'h0);

    // Full sequence.
    push_all();
    seq_cmd = 0;
    pulse_start();
    check("full_busy", {31'h0, busy}, 32'h1);
    wait_idle(6000, "full_seq");
    check("full_init_done", {31'h0, init_done}, 32'h1);
    check("full_err", {31'h0, err}, 32'h0);
    check("full_last_index", {28'h0, cmd_index}, 32'hA);
    check("full_cmd_count", n_cmds, 11);
    check("full_queue_empty", sb_q.size(), 0);

    // Restart from DONE, then a start pulse during GAP that must be ignored.
    push_all();
    seq_cmd = 0;
    pulse_start();
    check("restart_done_cleared", {31'h0, init_done}, 32'h0);
    check("restart_index", {28'h0, cmd_index}, 32'h0);
    n = 0;
    while (!(dut.state == GAP && seq_cmd == 2) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("reach_gap", {31'h0, n < 3000}, 32'h1);
    pulse_start();
    check("gap_start_index", {28'h0, cmd_index}, 32'h1);
    check("gap_start_busy", {31'h0, busy}, 32'h1);
    wait_idle(6000, "restart_seq");
    check("restart_cmd_count", n_cmds, 22);
    check("restart_queue_empty", sb_q.size(), 0);

    // Command 3 never finishes: timeout after TMO_N WAIT_DONE cycles, sequence carries on.
    hang_cmd = 3;
    push_all();
    seq_cmd = 0;
    pulse_start();
    wait_idle(8000, "timeout_seq");
    check("tmo_err", {31'h0, err}, 32'h1);
    check("tmo_init_done", {31'h0, init_done}, 32'h1);
    check("tmo_low_len", tmo_len, TMO_N + 1);
    check("tmo_err_before", {31'h0, last_err_low}, 32'h0);
    check("tmo_err_at_release", {31'h0, tmo_err_rise}, 32'h1);
    check("tmo_queue_empty", sb_q.size(), 0);
    hang_cmd = -1;

    // Asynchronous reset during WAIT_DONE of command 5.
    push_all();
    seq_cmd = 0;
    pulse_start();
    wait_cmds(6, 3000, "reach_cmd5");
    repeat (10) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_i2c_reset", {31'h0, i2c_reset}, 32'h1);
    check("mid_rst_i2c_data", {8'h00, i2c_data}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_init_done", {31'h0, init_done}, 32'h0);
    check("mid_rst_err", {31'h0, err}, 32'h0);
    check("mid_rst_cmd_index", {28'h0, cmd_index}, 32'h0);
    sb_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    n0 = n_cmds;
    repeat (40) @(negedge clock);
    check("post_rst_no_cmd", n_cmds, n0);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    push_all();
    seq_cmd = 0;
    pulse_start();
    wait_idle(6000, "post_rst_seq");
    check("post_rst_init_done", {31'h0, init_done}, 32'h1);
    check("post_rst_err", {31'h0, err}, 32'h0);
    check("post_rst_queue_empty", sb_q.size(), 0);

`ifdef CODEC_SEQ_VOLUME_EN
    // Volume command issued from DONE.
    vol_word = {8'h34, 7'h02, 2'b01, 7'h79};
    vv.idx  = 4'd10;
    vv.word = vol_word;
    sb_q.push_back(vv);
    vol_value = 7'h79;
    vol_req = 1'b1;
    @(negedge clock);
    vol_req = 1'b0;
    check("vol_busy", {31'h0, busy}, 32'h1);
    acks = 0;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
      if (vol_ack === 1'b1) acks++;
    end
    repeat (5) begin
      @(negedge clock);
      if (vol_ack === 1'b1) acks++;
    end
    check("vol_returned", {31'h0, n < 3000}, 32'h1);
    check("vol_ack_count", acks, 1);
    check("vol_init_done", {31'h0, init_done}, 32'h1);
    check("vol_queue_empty", sb_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
